// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory controller with valid/ready request and
// response channels, byte/half/word accesses with sign or zero extension, and
// a configurable response latency. One access is outstanding at a time.
//
// Build option: define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses as errors. Without it, misaligned addresses are silently rounded
// down to natural alignment and the access completes normally.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Last counter value spent in WAIT before moving to RESP.
  localparam logic [1:0] WAIT_LAST = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic        ready_en;

  logic        accept;
  logic [AW-1:0] word_idx;
  logic        out_of_range;
  logic        size_bad;
  logic        req_error;
  logic [1:0]  lane;
  logic [3:0]  byte_en;
  logic [31:0] wr_data;
  logic        mem_we;

  // Captured request attributes, held for the duration of the response.
  logic        we_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [31:0] rd_word;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept       = req_valid && req_ready;
  assign word_idx     = req_addr[AW+1:2];
  assign out_of_range = |req_addr[31:AW+2];
  assign size_bad     = (req_size == 2'b11);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misaligned;

  // Misaligned half/word accesses are rejected outright.
  always_comb begin
    misaligned = 1'b0;
    if (req_size == SIZE_HALF && req_addr[0])
      misaligned = 1'b1;
    else if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
      misaligned = 1'b1;
  end

  assign req_error = out_of_range || size_bad || misaligned;
  assign lane      = req_addr[1:0];
`else
  assign req_error = out_of_range || size_bad;

  // Round the byte offset down to the natural alignment of the access size.
  always_comb begin
    lane = req_addr[1:0];
    if (req_size == SIZE_HALF)
      lane = {req_addr[1], 1'b0};
    else if (req_size == SIZE_WORD)
      lane = 2'b00;
  end
`endif

  // Byte enables and lane-replicated store data for the selected size.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        byte_en[lane] = 1'b1;
        wr_data       = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        byte_en = 4'b1111;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

  assign mem_we = accept && req_we && !req_error;

  // Memory array: byte-lane writes and registered read, both on acceptance.
  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (accept)
      rd_word <= mem[word_idx];
  end

  // Capture request attributes needed to shape the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
    end else if (accept) begin
      we_q       <= req_we;
      err_q      <= req_error;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      lane_q     <= lane;
    end
  end

  // Hold req_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ready_en <= 1'b0;
    else
      ready_en <= 1'b1;
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // FSM next-state: accept in IDLE, burn LATENCY-1 cycles in WAIT, hold RESP
  // until the consumer takes the response.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_next   = 2'd0;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST)
          state_next = RESP;
        else
          cnt_next = cnt + 2'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          cnt_next   = 2'd0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  assign req_ready = ready_en && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;

  // Load result: lane select plus sign/zero extension; zero otherwise.
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte  = rd_word[{lane_q, 3'b000} +: 8];
    sel_half  = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    rsp_rdata = 32'd0;
    if (rsp_valid && !err_q && !we_q) begin
      case (size_q)
        SIZE_BYTE: rsp_rdata = {{24{sel_byte[7] & ~unsigned_q}}, sel_byte};
        SIZE_HALF: rsp_rdata = {{16{sel_half[15] & ~unsigned_q}}, sel_half};
        SIZE_WORD: rsp_rdata = rd_word;
        default:   rsp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to response valid (1..4).
REQ-003 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  block can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  in  32  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  access rejected.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid && req_ready; inputs sampled only then.
REQ-018 SHALL go IDLE -> RESP directly when LATENCY = 1, else IDLE -> WAIT, counting LATENCY-1 cycles, then RESP.
REQ-019 SHALL assert rsp_valid exactly LATENCY cycles after acceptance and hold it and rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-020 SHALL not accept a new request in the cycle of response handshake (one outstanding access, minimum 2-cycle throughput at LATENCY 1).
REQ-021 SHALL commit stores on the acceptance edge using byte enables from addr[1:0] and size: byte -> one lane, half -> lanes addr[1]*2..+1, word -> all four; unselected bytes unchanged.
REQ-022 SHALL read the addressed word on the acceptance edge, select the lane(s) by addr[1:0], and extend per req_unsigned.
REQ-023 SHALL index memory by addr[log2(DEPTH_WORDS)+1:2]; any set bit in addr[31:log2(DEPTH_WORDS)+2] is out-of-range.
REQ-024 SHALL treat out-of-range or req_size = 11 as error: no write, rsp_err = 1, rsp_rdata = 0.
REQ-025 SHALL not initialise or reset memory contents; loads of unwritten words return X in simulation.

Reset
REQ-026 SHALL, while rst_n = 0, force FSM to IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, req_ready 0.
REQ-027 SHALL raise req_ready 1 on the first rising edge after rst_n deasserts.
REQ-028 SHALL drop any pending response on reset mid-operation; a store already committed at acceptance remains in memory.

Configuration
REQ-029 SHALL, with DMEM_MISALIGN_CHECK_EN defined, flag half at odd address or word with addr[1:0] != 0 as error (rsp_err = 1, no write, rdata 0).
REQ-030 SHALL, without DMEM_MISALIGN_CHECK_EN, force misaligned addresses to natural alignment (clear addr[0] for half, addr[1:0] for word) and complete normally with rsp_err = 0.

Verification
REQ-031 SHALL cover: store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid exactly LATENCY cycles after acceptance.
REQ-032 SHALL cover: store byte 0x80 @0x13 over 0x00000000, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x10 -> 0x80000000.
REQ-033 SHALL cover: LATENCY 3, rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready 0 throughout, one handshake only.
REQ-034 SHALL cover: DEPTH_WORDS 256, store @0x400 -> rsp_err 1, word 0 unchanged on reload.
REQ-035 SHALL cover: load half @0x11 -> with macro rsp_err 1 and rdata 0; without macro returns half @0x10.
REQ-036 SHALL cover: rst_n pulsed low during WAIT -> rsp_valid never asserts, req_ready 1 one edge after release.
